// File: rtl/cla_if.sv
// rtl/cla_if.sv - operand/result bundle for the 4-bit pipelined carry-lookahead adder
interface cla_if;
   logic       cin;
   logic [3:0] x;
   logic [3:0] y;
   logic       cout;
   logic [3:0] z;

   modport master (output cin, output x, output y, input cout, input z);
   modport slave  (input cin, input x, input y, output cout, output z);
endinterface

// File: rtl/cla.sv
// rtl/cla.sv - two-stage 4-bit carry-lookahead adder: operand registers, lookahead sum, result registers
module cla (
   input  logic clk,
   input  logic rst_n,
   cla_if.slave bus
);

   logic [3:0] x_q, y_q, z_q, z_d;
   logic       cin_q, cout_q, cout_d;
   logic [3:0] g, p;
   logic [4:0] c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q    <= 4'b0000;
         y_q    <= 4'b0000;
         cin_q  <= 1'b0;
         z_q    <= 4'b0000;
         cout_q <= 1'b0;
      end else begin
         x_q    <= bus.x;
         y_q    <= bus.y;
         cin_q  <= bus.cin;
         z_q    <= z_d;
         cout_q <= cout_d;
      end
   end

   // Every carry is a flat sum of products over g, p and cin; none depends on a lower carry.
   always_comb begin
      g    = x_q & y_q;
      p    = x_q ^ y_q;
      c[0] = cin_q;
      c[1] = g[0] | (p[0] & cin_q);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_q);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_q);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin_q);
      z_d    = p ^ c[3:0];
      cout_d = c[4];
   end

   assign bus.z    = z_q;
   assign bus.cout = cout_q;

endmodule

// File: tb/tb_cla.sv
// tb/tb_cla.sv - randomized and directed check of cla against an arithmetic reference queue
module tb_cla;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_err;
   logic [4:0] exp_q[$];

   cla_if u_if ();

   cla u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Drive one operand pair, clock it in, then compare the result due from the previous edge.
   task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b, input logic ci);
      logic [4:0] want;
      u_if.x   = a;
      u_if.y   = b;
      u_if.cin = ci;
      exp_q.push_back(5'(int'(a) + int'(b) + int'(ci)));
      @(posedge clk);
      #1;
      want = (exp_q.size() >= 2) ? exp_q[exp_q.size() - 2] : 5'd0;
      check_eq(tag, {u_if.cout, u_if.z}, want);
      if (exp_q.size() > 2) void'(exp_q.pop_front());
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      u_if.x   = 4'd0;
      u_if.y   = 4'd0;
      u_if.cin = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_eq("reset_async", {u_if.cout, u_if.z}, 5'd0);
      @(posedge clk);
      #1;
      check_eq("reset_held", {u_if.cout, u_if.z}, 5'd0);
      #2;
      rst_n = 1'b1;

      // Directed cases, each held for two edges
      step("d_1_2",     4'b0001, 4'b0010, 1'b0); step("d_1_2",     4'b0001, 4'b0010, 1'b0);
      step("d_5_a",     4'b0101, 4'b1010, 1'b0); step("d_5_a",     4'b0101, 4'b1010, 1'b0);
      step("d_f_f",     4'b1111, 4'b1111, 1'b0); step("d_f_f",     4'b1111, 4'b1111, 1'b0);
      step("d_a_c",     4'b1010, 4'b1100, 1'b0); step("d_a_c",     4'b1010, 4'b1100, 1'b0);
      step("d_cin_all", 4'b1111, 4'b0000, 1'b1); step("d_cin_all", 4'b1111, 4'b0000, 1'b1);
      step("d_e_1",     4'b1110, 4'b0001, 1'b0); step("d_e_1",     4'b1110, 4'b0001, 1'b0);
      step("d_drain",   4'b0000, 4'b0000, 1'b0);
      check_eq("d_e_1_lit", {u_if.cout, u_if.z}, 5'b01111);

      // Exhaustive, back to back: each result checked two edges after its capture
      for (int i = 0; i < 512; i++)
         step("exhaustive", 4'(i), 4'(i >> 4), 1'(i >> 8));

      for (int i = 0; i < 200; i++)
         step("random", 4'($urandom), 4'($urandom), 1'($urandom));

      // Mid-operation reset with results in flight
      step("pre_rst", 4'hf, 4'hf, 1'b1);
      step("pre_rst", 4'h9, 4'h8, 1'b1);
      step("pre_rst", 4'h7, 4'h6, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("rst_immediate", {u_if.cout, u_if.z}, 5'd0);
      exp_q.delete();
      u_if.x   = 4'd0;
      u_if.y   = 4'd0;
      u_if.cin = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         check_eq("rst_hold", {u_if.cout, u_if.z}, 5'd0);
      end
      #2;
      rst_n = 1'b1;
      step("post_rst_zero", 4'd0, 4'd0, 1'b0);
      step("post_rst_zero", 4'd0, 4'd0, 1'b0);
      exp_q.delete();
      step("first_valid", 4'hc, 4'h7, 1'b1);
      check_eq("first_not_early", {u_if.cout, u_if.z}, 5'd0);
      step("first_valid", 4'h3, 4'h3, 1'b0);
      for (int i = 0; i < 20; i++)
         step("random2", 4'($urandom), 4'($urandom), 1'($urandom));
      step("drain", 4'd0, 4'd0, 1'b0);
      step("drain", 4'd0, 4'd0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cla.md
CLA -- requirements
Module: cla

Interface
- REQ-001: The block SHALL have no parameters; operand width is fixed at 4 bits.
- REQ-002: clk  input  1  rising-edge clock for all registers.
- REQ-003: rst_n  input  1  asynchronous, active-low reset; clears all registers immediately on assertion.
- REQ-004: cin  input  1  carry-in to bit 0.
- REQ-005: x  input  4  addend A, unsigned, bit 0 = LSB.
- REQ-006: y  input  4  addend B, unsigned, bit 0 = LSB.
- REQ-007: cout  output  1  registered carry-out of bit 3.
- REQ-008: z  output  4  registered sum bits.
- REQ-009: The block SHALL use one clock (clk) and an asynchronous, active-low reset (rst_n).

Function
- REQ-010: Stage 1 SHALL capture x, y and cin into input registers on every rising clk edge.
- REQ-011: From the input registers, the block SHALL compute per-bit generate g[i] = x[i] AND y[i] and propagate p[i] = x[i] XOR y[i].
- REQ-012: Carries SHALL be computed in lookahead form, each directly from g, p and cin, with no rippling:
  - c1 = g0 | p0·cin
  - c2 = g1 | p1·g0 | p1·p0·cin
  - c3 = g2 | p2·g1 | p2·p1·g0 | p2·p1·p0·cin
  - c4 = g3 | p3·g2 | p3·p2·g1 | p3·p2·p1·g0 | p3·p2·p1·p0·cin
- REQ-013: Sum bits SHALL be z[i] = p[i] XOR c[i], with c0 = cin.
- REQ-014: Stage 2 SHALL register z and cout = c4 on the rising clk edge.
- REQ-015: {cout, z} SHALL equal x + y + cin, taken modulo 32 as a 5-bit result.
- REQ-016: Latency SHALL be exactly 2 rising edges from input capture to the result appearing on z and cout.
- REQ-017: Throughput SHALL be one addition per cycle; the block has no handshake and no stall.
- REQ-018: Back-to-back input changes on consecutive cycles SHALL produce results in the same order, each 2 cycles later.
- REQ-019: Overflow SHALL wrap: z holds the low 4 bits and cout holds bit 4; no saturation is applied.
- REQ-020: Outputs SHALL be glitch-free between clock edges, because they are driven only by registers.

Reset
- REQ-021: While rst_n = 0, all input and output registers SHALL hold 0, so z = 4'b0000 and cout = 0 regardless of clk.
- REQ-022: Reset assertion SHALL take effect immediately without waiting for clk.
- REQ-023: Reset asserted mid-operation SHALL flush all in-flight results; those results SHALL never appear on the outputs.
- REQ-024: After rst_n deasserts, the first valid result SHALL appear 2 rising edges after the first capture edge.
- REQ-025: Outputs SHALL remain 0 until that first valid result reaches the output registers.

Verification
- REQ-026: Arithmetic cases, each with inputs held stable for 2 edges, SHALL produce:
  - x=0001, y=0010, cin=0 -> z=0011, cout=0
  - x=0101, y=1010, cin=0 -> z=1111, cout=0
  - x=1111, y=1111, cin=0 -> z=1110, cout=1
  - x=1010, y=1100, cin=0 -> z=0110, cout=1
- REQ-027: Carry-in propagation through all 4 bits: x=1111, y=0000, cin=1 -> z=0000, cout=1; x=1110, y=0001, cin=0 -> z=1111, cout=0.
- REQ-028: Latency check: apply a new operand pair on every edge; each result SHALL appear exactly 2 edges later, in order.
- REQ-029: Reset check: assert rst_n=0 between clock edges while z is nonzero -> z=0000 and cout=0 immediately; hold 0 for 2 edges after release with zero inputs.
- REQ-030: Exhaustive check: all 512 combinations of x, y and cin -> {cout, z} == x + y + cin, compared 2 cycles after application.
